coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/vm_pkg.sv | 19 +
 rtl/coin_debounce.sv | 59 +++++
 rtl/coin_acceptor.sv | 132 +++++++++++++
 tb/tb_coin_acceptor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Coin code constants shared between the coin acceptor and the
//               vending FSM that consumes its 2-bit coin code.
// Contents    : coin_t (2-bit coin code type)
//               COIN_NONE / COIN_5 / COIN_10 code values
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_5    = 2'b01;
  localparam coin_t COIN_10   = 2'b10;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// ============================================================================
// Module      : coin_debounce
// Description : One coin slot front end: two-flop synchronizer, consecutive-
//               cycle debounce filter and a one-cycle pulse on each accepted
//               low-to-high change of the debounced level.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active low
//               raw  - asynchronous sensor line
//               rise - one-cycle pulse, debounced level just went high
// Revision    : 1.0 - initial release
// ============================================================================
module coin_debounce #(
  parameter int DEB_CYCLES = 4  // legal range 2..15
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [3:0] C_LAST = 4'(DEB_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [3:0] r_cnt;
  logic       r_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        // The cycle the counter would reach DEB_CYCLES is the flip cycle.
        if (r_cnt == C_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
          r_rise  <= ~r_level;  // only a 0->1 change is a coin event
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign rise = r_rise;

endmodule : coin_debounce
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Two-slot coin acceptor. Debounced coin events are queued in a
//               small FIFO and issued one per cycle as a 2-bit coin code to
//               the vending FSM; coins that cannot be accepted are returned.
// Ports       : clk         - clock
//               rst         - asynchronous reset, active low
//               coin5_raw   - 5-unit slot sensor (asynchronous)
//               coin10_raw  - 10-unit slot sensor (asynchronous)
//               enable      - downstream accepts coins (0 = return coins)
//               hold        - downstream busy, stall code issue
//               coin_code   - registered coin code (00 none, 01 five, 10 ten)
//               coin_return - one-cycle pulse per rejected coin
//               overflow    - sticky, a coin was rejected on a full queue
//               fifo_count  - number of queued coin events
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEB_CYCLES = 4,  // 2..15
  parameter int FIFO_DEPTH = 4   // power of two, 2..16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          enable,
  input  logic                          hold,
  output logic [1:0]                    coin_code,
  output logic                          coin_return,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  logic          w_rise5;
  logic          w_rise10;
  logic          w_pop;
  logic          w_full;
  logic          w_have;
  coin_t         w_coin;
  logic          w_pend_next;
  logic          w_push;
  logic          w_reject;
  logic          w_ovf_set;

  logic          r_pend10;
  coin_t         r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  coin_t         r_code;
  logic          r_ret;
  logic          r_ovf;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin5_raw),
    .rise (w_rise5)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
    .clk  (clk),
    .rst  (rst),
    .raw  (coin10_raw),
    .rise (w_rise10)
  );

  // One coin is handled per cycle: a new 5 first, then a parked 10, then a
  // new 10. A 10 that collides with a 5 is parked for the following cycle.
  always_comb begin
    w_pop       = (r_count != '0) && !hold;
    w_full      = (r_count == C_FULL);
    w_have      = 1'b0;
    w_coin      = COIN_NONE;
    w_pend_next = r_pend10;
    if (w_rise5) begin
      w_have = 1'b1;
      w_coin = COIN_5;
      if (w_rise10) w_pend_next = 1'b1;
    end else if (r_pend10) begin
      w_have      = 1'b1;
      w_coin      = COIN_10;
      w_pend_next = w_rise10;  // slot freed this cycle, so a new 10 may park
    end else if (w_rise10) begin
      w_have = 1'b1;
      w_coin = COIN_10;
    end
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    w_push    = w_have && enable && (!w_full || w_pop);
    w_reject  = w_have && !w_push;
    w_ovf_set = w_have && enable && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend10 <= 1'b0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_code   <= COIN_NONE;
      r_ret    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend10 <= w_pend_next;
      r_ret    <= w_reject;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_code  <= w_pop ? r_mem[r_rd] : COIN_NONE;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_coin;
  end

  assign coin_code   = r_code;
  assign coin_return = r_ret;
  assign overflow    = r_ovf;
  assign fifo_count  = r_count;

endmodule : coin_acceptor
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Self-checking bench for coin_acceptor. Directed scenarios plus
//               randomized slot activity compared cycle by cycle against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       enable;
  logic       hold;
  logic [1:0] coin_code;
  logic       coin_return;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_tests;
  int n_fail;

  coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin5_raw   (coin5_raw),
    .coin10_raw  (coin10_raw),
    .enable      (enable),
    .hold        (hold),
    .coin_code   (coin_code),
    .coin_return (coin_return),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: per slot, the level seen two samples late must disagree
  // with the accepted level for DEB samples in a row to be accepted; coin
  // events go into a plain queue bounded at DEPTH entries.
  // --------------------------------------------------------------------------
  bit       m_s1 [2];
  bit       m_s2 [2];
  bit       m_deb[2];
  bit       m_ev [2];
  int       m_run[2];
  bit       m_pend;
  bit [1:0] m_q[$];
  bit [1:0] e_code;
  bit       e_ret;
  bit       e_ovf;

  logic [6:0] act;
  assign act = {coin_code, coin_return, overflow, fifo_count};

  function automatic logic [6:0] exp_vec();
    return {e_code, e_ret, e_ovf, 3'(m_q.size())};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_ev[i] = 0; m_run[i] = 0;
    end
    m_pend = 0;
    m_q.delete();
    e_code = 2'b00;
    e_ret  = 0;
    e_ovf  = 0;
  endtask

  task automatic model_step();
    bit       pop;
    bit       have;
    bit [1:0] coin;
    bit       raw;
    pop    = (m_q.size() > 0) && !hold;
    e_code = pop ? m_q[0] : 2'b00;
    e_ret  = 0;
    have   = 0;
    coin   = 2'b00;
    if (m_ev[0]) begin
      have = 1; coin = 2'b01;
      if (m_ev[1]) m_pend = 1;
    end else if (m_pend) begin
      have = 1; coin = 2'b10;
      m_pend = m_ev[1];
    end else if (m_ev[1]) begin
      have = 1; coin = 2'b10;
    end
    if (pop) void'(m_q.pop_front());
    if (have) begin
      if (!enable) e_ret = 1;
      else if (m_q.size() < DEPTH) m_q.push_back(coin);
      else begin
        e_ret = 1;
        e_ovf = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      raw = (i == 0) ? coin5_raw : coin10_raw;
      if (m_s2[i] != m_deb[i]) m_run[i]++;
      else m_run[i] = 0;
      m_ev[i] = 0;
      if (m_run[i] == DEB) begin
        m_deb[i] = !m_deb[i];
        m_run[i] = 0;
        m_ev[i]  = m_deb[i];
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw;
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    model_reset();
    repeat (2) tick();
    #2;
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_tests++;
    if (act !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, want 0000000", act);
    end
    model_reset();
    repeat (2) tick();
    #2;
    rst = 1'b1;
  endtask

  task automatic test_single_five();
    int n5, first, nret;
    apply_reset();
    enable = 1; hold = 0;
    n5 = 0; first = -1; nret = 0;
    coin5_raw = 1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) coin5_raw = 0;
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_five t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_code == 2'b01) begin
        n5++;
        if (first < 0) first = t;
      end
      if (coin_return) nret++;
    end
    n_tests++;
    if (n5 != 1 || first != 8 || nret != 0) begin
      n_fail++;
      $display("FAIL single_five_pulse: got n=%0d at tick %0d returns=%0d, want n=1 at tick 8 returns=0", n5, first, nret);
    end
  endtask

  task automatic test_glitch();
    int ncode;
    apply_reset();
    enable = 1; hold = 0;
    ncode = 0;
    coin10_raw = 1;
    for (int t = 1; t <= 25; t++) begin
      if (t == 4) coin10_raw = 0;
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_code != 2'b00) ncode++;
    end
    n_tests++;
    if (ncode != 0) begin
      n_fail++;
      $display("FAIL glitch_no_code: got %0d codes, want 0", ncode);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] c8, c9;
    apply_reset();
    enable = 1; hold = 0;
    c8 = 2'b00; c9 = 2'b00;
    coin5_raw = 1; coin10_raw = 1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) begin coin5_raw = 0; coin10_raw = 0; end
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL simultaneous t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (t == 8) c8 = coin_code;
      if (t == 9) c9 = coin_code;
    end
    n_tests++;
    if (c8 !== 2'b01 || c9 !== 2'b10) begin
      n_fail++;
      $display("FAIL simultaneous_order: got %b then %b, want 01 then 10", c8, c9);
    end
  endtask

  task automatic test_overflow();
    int nret, n01, first;
    apply_reset();
    enable = 1; hold = 1;
    nret = 0;
    for (int t = 0; t < 70; t++) begin
      coin5_raw = (t < 60) && ((t % 12) < 6);
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL overflow_fill t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_return) nret++;
    end
    n_tests++;
    if (fifo_count !== 3'd4 || nret != 1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: got count=%0d returns=%0d ovf=%b, want count=4 returns=1 ovf=1", fifo_count, nret, overflow);
    end
    hold = 0;
    n01 = 0; first = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL overflow_drain t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_code == 2'b01) begin
        n01++;
        if (first < 0) first = t;
      end
    end
    n_tests++;
    if (n01 != 4 || first != 1) begin
      n_fail++;
      $display("FAIL overflow_drain_codes: got %0d codes from tick %0d, want 4 from tick 1", n01, first);
    end
  endtask

  task automatic test_disabled();
    int nret, ncode, maxcnt;
    apply_reset();
    enable = 0; hold = 0;
    nret = 0; ncode = 0; maxcnt = 0;
    coin10_raw = 1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) coin10_raw = 0;
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL disabled t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_return) nret++;
      if (coin_code != 2'b00) ncode++;
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
    end
    n_tests++;
    if (nret != 1 || ncode != 0 || maxcnt != 0) begin
      n_fail++;
      $display("FAIL disabled_return: got returns=%0d codes=%0d maxcount=%0d, want 1 0 0", nret, ncode, maxcnt);
    end
    enable = 1;
  endtask

  task automatic test_reset_queued();
    int nact;
    apply_reset();
    enable = 1; hold = 1;
    for (int t = 0; t < 32; t++) begin
      coin5_raw = (t < 24) && ((t % 12) < 6);
      tick();
    end
    n_tests++;
    if (fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL queued_before_reset: got count=%0d, want 2", fifo_count);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (act !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b, want 0000000", act);
    end
    model_reset();
    repeat (2) tick();
    #2;
    rst = 1'b1;
    hold = 0;
    nact = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL after_reset t=%0d: got %b, want %b", t, act, exp_vec());
      end
      if (coin_code != 2'b00 || coin_return) nact++;
    end
    n_tests++;
    if (nact != 0) begin
      n_fail++;
      $display("FAIL after_reset_silent: got %0d active cycles, want 0", nact);
    end
  endtask

  task automatic test_random();
    int left5, left10;
    apply_reset();
    enable = 1; hold = 0;
    left5 = 0; left10 = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) begin
        apply_reset();
        left5 = 0; left10 = 0;
      end
      if (left5 == 0) begin
        coin5_raw = ~coin5_raw;
        left5 = int'($urandom_range(1, 14));
      end
      if (left10 == 0) begin
        coin10_raw = ~coin10_raw;
        left10 = int'($urandom_range(1, 14));
      end
      left5--;
      left10--;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      tick();
      n_tests++;
      if (act !== exp_vec()) begin
        n_fail++;
        $display("FAIL random t=%0d: got %b, want %b", t, act, exp_vec());
      end
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    enable     = 1'b1;
    hold       = 1'b0;
    model_reset();
    #3;
    test_reset();
    test_single_five();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_disabled();
    test_reset_queued();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_coin_acceptor
`default_nettype wire
